multiplier_divider: RTL and testbench
=====================================

MULTIPLIER_DIVIDER -- requirements
Module: multiplier_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter FRAC_BITS, default 20, number of fractional bits (signed two's-complement fixed point, Q11.20 at defaults).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; all state updates on the rising clk edge.
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  request operation, sampled on rising clk.
REQ-007 Port: op  input  1  0 = multiply, 1 = divide.
REQ-008 Port: a  input  WIDTH  signed operand (multiplicand or dividend).
REQ-009 Port: b  input  WIDTH  signed operand (multiplier or divisor).
REQ-010 Port: result  output  WIDTH  signed fixed-point result, registered.
REQ-011 Port: busy  output  1  high while an operation is in progress.
REQ-012 Port: done  output  1  one-cycle pulse when result becomes valid.
REQ-013 Port: overflow  output  1  result saturated, valid with done.
REQ-014 Port: div_by_zero  output  1  divide with b == 0, valid with done.

Function
REQ-015 start accepted only when busy is low; a, b, op captured on the accepting edge; start while busy SHALL be ignored.
REQ-016 States: IDLE, MUL (product stage), DIV (iterating), FINISH; IDLE->MUL or IDLE->DIV on accepted start; MUL->FINISH after 1 cycle; DIV->FINISH after final quotient bit; FINISH->IDLE after 1 cycle.
REQ-017 busy SHALL be high from the cycle after acceptance until done is asserted; done high exactly one cycle, busy low in that same cycle; a new start SHALL be accepted in the done cycle.
REQ-018 Multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC_BITS (truncation toward negative infinity).
REQ-019 Multiply latency: done asserted 2 cycles after the accepting edge.
REQ-020 Multiply: if shifted product exceeds signed WIDTH range, result SHALL saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative) and overflow SHALL be 1.
REQ-021 Divide: quotient = (|a| << FRAC_BITS) / |b| by restoring division, one quotient bit per cycle, WIDTH+FRAC_BITS iterations; sign = sign(a) XOR sign(b); truncation toward zero.
REQ-022 Divide latency: done asserted WIDTH+FRAC_BITS+2 cycles (54 at defaults) after the accepting edge, independent of operand values.
REQ-023 Divide: if magnitude quotient exceeds signed WIDTH range, saturate per REQ-020 sign rule and set overflow.
REQ-024 Divide with b == 0: no iteration skip (same latency), result 0x7FFFFFFF if a >= 0 else 0x80000000, div_by_zero = 1, overflow = 0.
REQ-025 Operand -2^(WIDTH-1) SHALL be handled via WIDTH+1-bit magnitude, no wrap.
REQ-026 result, overflow, div_by_zero SHALL hold their values from done until the next done.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, result = 0, busy = 0, done = 0, overflow = 0, div_by_zero = 0.
REQ-028 Reset mid-operation SHALL abort it with no done pulse; first edge after rst_n release is able to accept start.

Verification
REQ-029 mul a=0x00200000 (2.0), b=0x00500000 (5.0) -> done 2 cycles later, result 0x00A00000 (10.0), overflow 0.
REQ-030 div a=0x00A00000 (10.0), b=0x00200000 (2.0) -> done 54 cycles later, result 0x00500000 (5.0); also a=0x00100000, b=0x00300000 -> 0x00055555.
REQ-031 mul a=0xFFE80000 (-1.5), b=0x00200000 -> 0xFFD00000 (-3.0); mul 0x40000000 x 0x40000000 -> 0x7FFFFFFF, overflow 1.
REQ-032 div a=0xFFF00000 (-1.0), b=0 -> 0x80000000, div_by_zero 1, overflow 0, latency 54.
REQ-033 start div then start mul at cycle 10 while busy -> mul ignored, single done with division result.
REQ-034 rst_n low at cycle 20 of a division -> all outputs 0 at once, no done; new mul after release completes normally.

Source files
------------

// File: rtl/multiplier_divider.sv
// Signed fixed-point multiplier / restoring divider.
// Multiply finishes two cycles after the accepting edge. Divide runs one setup
// cycle plus WIDTH+FRAC_BITS quotient-bit iterations, so its latency does not
// depend on the operand values. Results saturate on overflow.
module multiplier_divider #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    div_by_zero
);

  localparam int N  = WIDTH + FRAC_BITS;   // quotient bits produced
  localparam int CW = $clog2(N + 1);       // counter spans setup + N iterations

  localparam logic [CW-1:0]    CNT_LAST  = CW'(N);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [N-1:0]     Q_LIM_POS = {{FRAC_BITS{1'b0}}, MAX_POS};
  localparam logic [N-1:0]     Q_LIM_NEG = {{FRAC_BITS{1'b0}}, MIN_NEG};

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

  state_t state_reg, state_next;

  logic signed [WIDTH-1:0]   a_reg, b_reg;
  logic                      op_reg, neg_reg, a_neg_reg, bz_reg;
  logic [CW-1:0]             cnt_reg;
  logic [WIDTH:0]            divisor_reg;
  logic [WIDTH-1:0]          rem_reg;
  logic [N-1:0]              quo_reg;     // dividend bits shift out, quotient bits shift in
  logic signed [2*WIDTH-1:0] prod_reg;

  // Operand magnitudes. |a| fits WIDTH unsigned bits even for the most negative
  // value; the divisor keeps WIDTH+1 bits so the compare never wraps.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   b_ext, abs_b;

  // Restoring-division step and final result formatting.
  logic [WIDTH:0]            rem_shift, rem_sub;
  logic                      rem_ge;
  logic signed [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]            hi_bits;
  logic                      mul_ovf, div_ovf;
  logic [WIDTH-1:0]          div_mag;

  assign busy = (state_reg != IDLE);

  // Combinational datapath: magnitudes, one division step, saturation checks.
  always_comb begin
    abs_a     = a_reg[WIDTH-1] ? -a_reg : a_reg;
    b_ext     = {b_reg[WIDTH-1], b_reg};
    abs_b     = b_reg[WIDTH-1] ? -b_ext : b_ext;
    rem_shift = {rem_reg, quo_reg[N-1]};
    rem_ge    = (rem_shift >= divisor_reg);
    rem_sub   = rem_shift - divisor_reg;
    shifted   = prod_reg >>> FRAC_BITS;
    hi_bits   = shifted[2*WIDTH-1:WIDTH-1];
    mul_ovf   = !((&hi_bits) || (~|hi_bits));
    div_ovf   = neg_reg ? (quo_reg > Q_LIM_NEG) : (quo_reg > Q_LIM_POS);
    div_mag   = quo_reg[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = op ? DIV : MUL;
      MUL:     state_next = FINISH;
      DIV:     if (cnt_reg == CNT_LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, product, division iterations and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= 1'b0;
      neg_reg     <= 1'b0;
      a_neg_reg   <= 1'b0;
      bz_reg      <= 1'b0;
      cnt_reg     <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      prod_reg    <= '0;
      result      <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            neg_reg   <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg_reg <= a[WIDTH-1];
            bz_reg    <= (b == '0);
            cnt_reg   <= '0;
          end
        end
        MUL: prod_reg <= a_reg * b_reg;
        DIV: begin
          cnt_reg <= cnt_reg + CNT_ONE;
          if (cnt_reg == '0) begin
            // Setup cycle: load |a| << FRAC_BITS and the divisor magnitude.
            divisor_reg <= abs_b;
            rem_reg     <= '0;
            quo_reg     <= {abs_a, {FRAC_BITS{1'b0}}};
          end else begin
            rem_reg <= rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_reg <= {quo_reg[N-2:0], rem_ge};
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (!op_reg) begin
            overflow    <= mul_ovf;
            div_by_zero <= 1'b0;
            if (mul_ovf) result <= prod_reg[2*WIDTH-1] ? MIN_NEG : MAX_POS;
            else         result <= shifted[WIDTH-1:0];
          end else if (bz_reg) begin
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
            result      <= a_neg_reg ? MIN_NEG : MAX_POS;
          end else begin
            overflow    <= div_ovf;
            div_by_zero <= 1'b0;
            if (div_ovf) result <= neg_reg ? MIN_NEG : MAX_POS;
            else         result <= neg_reg ? -div_mag : div_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_divider.sv
// Directed and randomized bench for multiplier_divider (WIDTH=32, FRAC_BITS=20).
// Expectations are pushed to a scoreboard queue at issue and popped at done.
module tb_multiplier_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result;
  logic        busy, done, overflow, div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        ovf;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  multiplier_divider #(.WIDTH(32), .FRAC_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .result(result), .busy(busy), .done(done), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [31:0] r, input bit o,
                              input bit d, input int l);
    exp_t e;
    e.tag = tag; e.res = r; e.ovf = o; e.dbz = d; e.lat = l;
    return e;
  endfunction

  // Reference model using 64-bit integer arithmetic.
  function automatic exp_t model(input string tag, input bit o, input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx, sy, p, q, ma, mb;
    bit     neg;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.tag = tag; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = o ? 54 : 2; e.res = '0;
    if (!o) begin
      p = (sx * sy) >>> 20;
      if (p > 64'sd2147483647)       begin e.ovf = 1'b1; e.res = 32'h7FFFFFFF; end
      else if (p < -64'sd2147483648) begin e.ovf = 1'b1; e.res = 32'h80000000; end
      else e.res = p[31:0];
    end else if (sy == 0) begin
      e.dbz = 1'b1;
      e.res = (sx < 0) ? 32'h80000000 : 32'h7FFFFFFF;
    end else begin
      ma  = (sx < 0) ? -sx : sx;
      mb  = (sy < 0) ? -sy : sy;
      q   = (ma <<< 20) / mb;
      neg = (sx < 0) != (sy < 0);
      if (q > (neg ? 64'sd2147483648 : 64'sd2147483647)) begin
        e.ovf = 1'b1;
        e.res = neg ? 32'h80000000 : 32'h7FFFFFFF;
      end else begin
        if (neg) q = -q;
        e.res = q[31:0];
      end
    end
    return e;
  endfunction

  // Drive one start pulse; returns #1 after the accepting edge.
  task automatic send(input bit o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare.
  task automatic wait_done(input int cyc_in);
    int   cyc;
    bit   busy_ok;
    exp_t e;
    cyc = cyc_in;
    busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_done"},    done, 1);
    chk({e.tag, "_latency"}, cyc, e.lat);
    chk({e.tag, "_result"},  result, e.res);
    chk({e.tag, "_ovf"},     overflow, e.ovf);
    chk({e.tag, "_dbz"},     div_by_zero, e.dbz);
    chk({e.tag, "_busy"},    {busy_ok, busy}, 2'b10);
    $display("txn %s lat=%0d result=%h ovf=%b dbz=%b", e.tag, cyc, result, overflow, div_by_zero);
  endtask

  initial begin
    bit          o;
    logic [31:0] x, y;
    int          cyc;
    bit          quiet;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {result, busy, done, overflow, div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed multiplies and divides
    send(0, 32'h00200000, 32'h00500000, mk("mul_2x5", 32'h00A00000, 0, 0, 2));
    wait_done(0);
    send(1, 32'h00A00000, 32'h00200000, mk("div_10_2", 32'h00500000, 0, 0, 54));
    wait_done(0);
    send(1, 32'h00100000, 32'h00300000, mk("div_1_3", 32'h00055555, 0, 0, 54));
    wait_done(0);
    send(0, 32'hFFE80000, 32'h00200000, mk("mul_neg", 32'hFFD00000, 0, 0, 2));
    wait_done(0);
    send(0, 32'h40000000, 32'h40000000, mk("mul_sat", 32'h7FFFFFFF, 1, 0, 2));
    wait_done(0);
    send(1, 32'hFFF00000, 32'h00000000, mk("div_zero", 32'h80000000, 0, 1, 54));
    wait_done(0);
    send(1, 32'h00100000, 32'h00000000, mk("div_zero_pos", 32'h7FFFFFFF, 0, 1, 54));
    wait_done(0);
    send(1, 32'h80000000, 32'h00100000, model("div_minneg", 1, 32'h80000000, 32'h00100000));
    wait_done(0);
    send(0, 32'h80000000, 32'h80000000, model("mul_minneg", 0, 32'h80000000, 32'h80000000));
    wait_done(0);
    send(1, 32'h7FFFFFFF, 32'h00000001, model("div_ovf", 1, 32'h7FFFFFFF, 32'h00000001));
    wait_done(0);
    send(1, 32'h00300000, 32'hFFE00000, model("div_negq", 1, 32'h00300000, 32'hFFE00000));
    wait_done(0);

    // Randomized operations against the model
    for (int i = 0; i < 8; i++) begin
      o = 1'($urandom_range(0, 1));
      x = 32'($signed($urandom) >>> $urandom_range(0, 12));
      y = 32'($signed($urandom) >>> $urandom_range(4, 16));
      send(o, x, y, model($sformatf("rand%0d", i), o, x, y));
      wait_done(0);
    end

    // Start while busy is ignored
    send(1, 32'h00A00000, 32'h00200000, mk("div_busy", 32'h00500000, 0, 0, 54));
    cyc = 0;
    while (cyc < 9) begin @(posedge clk); #1; cyc++; end
    @(negedge clk);
    op = 1'b0; a = 32'h00200000; b = 32'h00200000; start = 1'b1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0;
    wait_done(cyc);
    quiet = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    chk("busy_start_no_extra_done", quiet, 1);

    // Reset in the middle of a division
    send(1, 32'h00100000, 32'h00300000, mk("div_aborted", 32'h0, 0, 0, 54));
    cyc = 0;
    while (cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {result, busy, done, overflow, div_by_zero}, 0);
    void'(sb.pop_front());
    quiet = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0; end
    chk("reset_abort_no_done", quiet, 1);
    send(0, 32'hFFE80000, 32'hFFE80000, mk("mul_after_reset", 32'h00240000, 0, 0, 2));
    wait_done(0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
